ps2_key_tracker: RTL

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver plus make/break decoder: tracks the last pressed key, held state and press count.
// Latency: decoder outputs update one clk after the 11th PS/2 falling edge is detected (3-flop sync ahead of that).
// Backpressure: none; bytes are consumed as they arrive, and bad frames are dropped with a one-cycle frame_err.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       key_down,
  output logic [7:0] press_count,
  output logic       frame_err
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TMO = IW'(TIMEOUT_CYCLES);

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {IDLE, HELD, BRK} state_t;

  // Synchronizers: index 0 is the newest sample, index 2 the oldest.
  logic [2:0]    ps2c_q, ps2d_q;
  logic          fall;

  // Frame receiver state.
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
  logic          byte_vld;
  logic [7:0]    byte_dat;

  // Decoder state and registered outputs.
  state_t        state_q, state_d;
  logic [7:0]    sc_q, sc_d;
  logic          down_q, down_d;
  logic [7:0]    cnt_q, cnt_d;

  assign fall = ps2c_q[2] & ~ps2c_q[1];

  // Bring the raw keyboard lines into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_q <= 3'b111;
      ps2d_q <= 3'b111;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[1:0], ps2_data};
    end
  end

  // Bit sampling, frame validation on the 11th edge, and partial-frame timeout.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    idle_d    = idle_q;
    err_d     = 1'b0;
    byte_vld  = 1'b0;
    byte_dat  = frame_q[8:1];
    if (fall) begin
      // An edge always wins over a coincident timeout.
      idle_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // frame_q[0]=start, [8:1]=data LSB first, [9]=parity; current sample is stop.
        if (!frame_q[0] && ps2d_q[2] && (^frame_q[9:1])) begin
          byte_vld = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        frame_d   = {ps2d_q[2], frame_q[9:1]};
      end
    end else begin
      // Saturate so a long idle line never wraps back into a false timeout.
      if (idle_q != TMO) begin
        idle_d = idle_q + IW'(1);
      end
      if (idle_q == TMO && bit_cnt_q != 4'd0) begin
        bit_cnt_d = 4'd0;
      end
    end
  end

  // Receiver and decoder registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= 4'd0;
      frame_q   <= '0;
      idle_q    <= '0;
      err_q     <= 1'b0;
      state_q   <= IDLE;
      sc_q      <= 8'h00;
      down_q    <= 1'b0;
      cnt_q     <= 8'h00;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      state_q   <= state_d;
      sc_q      <= sc_d;
      down_q    <= down_d;
      cnt_q     <= cnt_d;
    end
  end

  // Decoder next state: one step per accepted byte; E0 is transparent everywhere.
  always_comb begin
    state_d = state_q;
    if (byte_vld && byte_dat != EXT_CODE) begin
      unique case (state_q)
        IDLE:    state_d = (byte_dat == BRK_CODE) ? BRK : HELD;
        HELD:    state_d = (byte_dat == BRK_CODE) ? BRK : HELD;
        BRK:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Decoder outputs: new press loads the code and bumps the count; break clears key_down.
  always_comb begin
    sc_d   = sc_q;
    down_d = down_q;
    cnt_d  = cnt_q;
    if (byte_vld && byte_dat != EXT_CODE) begin
      unique case (state_q)
        IDLE: begin
          if (byte_dat != BRK_CODE) begin
            sc_d   = byte_dat;
            down_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end
        end
        HELD: begin
          // Same code again is typematic repeat, not a new press.
          if (byte_dat != BRK_CODE && byte_dat != sc_q) begin
            sc_d  = byte_dat;
            cnt_d = cnt_q + 8'd1;
          end
        end
        BRK: begin
          down_d = 1'b0;
        end
        default: begin
          down_d = down_q;
        end
      endcase
    end
  end

  assign scancode    = sc_q;
  assign key_down    = down_q;
  assign press_count = cnt_q;
  assign frame_err   = err_q;

endmodule
